program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Boot-time instruction-memory loader; sits directly upstream of the instruction-fetch stage.
- Accepts a byte stream from a serial receiver, assembles 32-bit big-endian instruction words and writes them sequentially into the 256-word instruction memory.
- Holds the CPU in reset while loading and releases it when the image is complete.

Parameters:
- ADDRESS_WIDTH, 8, instruction-memory word-address width (256 words).
- START_BYTE, 8'hA5, byte that opens a load frame.
- TIMEOUT_CYCLES, 1000000, maximum idle cycles between bytes inside a frame.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- byteValid  input  1  incoming byte valid.
- byteData  input  8  incoming byte.
- byteReady  output  1  loader can accept a byte.
- imemWrite  output  1  instruction-memory write strobe.
- imemAddress  output  ADDRESS_WIDTH  word address for the write.
- imemData  output  32  instruction word for the write.
- cpuReset  output  1  active-high reset to the CPU stages.
- loading  output  1  high while a frame is in progress.
- done  output  1  high after a successful load.
- error  output  1  sticky error flag.

Behaviour:
- Byte transfer occurs on a rising edge with byteValid && byteReady.
- Reset (reset low, asynchronous) forces: state IDLE, cpuReset=1, imemWrite=0, imemAddress=0, imemData=0, byteReady=1, loading=0, done=0, error=0, byte index=0, word count=0, timeout counter=0.
- Reset mid-frame aborts immediately; partial words are discarded.
- States:
  - IDLE: byteReady=1. Non-START bytes are discarded. START_BYTE -> COUNT; this sets cpuReset=1, loading=1, done=0, error=0, imemAddress=0.
  - COUNT: next byte is N, the number of words; N=0 means 256. -> LOAD.
  - LOAD: byteReady=1. Bytes are shifted in big-endian: the first byte lands in imemData[31:24]. After the 4th byte -> WRITE.
  - WRITE: exactly one cycle. byteReady=0 and imemWrite=1, with imemAddress/imemData stable. On exit, imemAddress increments by 1, wrapping 255->0, and remaining words decrement. If remaining > 0 -> LOAD; else -> CHECK when the checksum option is enabled, otherwise DONE.
  - DONE: cpuReset=0, done=1, loading=0. Entered the cycle after the last WRITE. START_BYTE here re-enters COUNT and reasserts cpuReset=1 the next cycle. Other bytes are discarded.
- imemWrite is never high outside WRITE. A 256-word frame writes addresses 0..255 and leaves imemAddress at 0.
- Timeout:
  - Counter runs in COUNT, LOAD and CHECK; it clears on every accepted byte.
  - When it reaches TIMEOUT_CYCLES: -> IDLE, error=1, loading=0, cpuReset stays 1. Words already written remain in memory.
- error is sticky until the next START_BYTE or reset.
- A START_BYTE value received inside COUNT, LOAD or CHECK is treated as data, not as a restart.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- When defined:
  - Running XOR of all bytes after START_BYTE (count byte plus data bytes) is kept.
  - After the last WRITE the block enters CHECK and accepts one more byte.
  - If that byte equals the XOR -> DONE.
  - Else -> IDLE with error=1 and cpuReset held at 1.
- When undefined: no CHECK state and no XOR register; DONE follows the last WRITE directly.

Test Plan:
1. Reset release, then A5 02 3C 08 00 01 20 09 00 02 -> imemWrite pulses twice: addr 0 / 32'h3C080001 and addr 1 / 32'h20090002; cpuReset falls and done=1 the cycle after the second write.
2. Bytes 11 22 A5 01 DE AD BE EF with byteValid gapped by random 0-5 cycles -> 11 and 22 ignored; single write addr 0 / 32'hDEADBEEF; byteReady low only in the WRITE cycle.
3. TIMEOUT_CYCLES=50, send A5 01 DE AD then stall 50 cycles -> state IDLE, error=1, cpuReset=1, no imemWrite; next A5 clears error.
4. Count byte 00 with 1024 data bytes -> 256 writes to addresses 0..255, imemAddress ends at 0, done=1.
5. After done, send A5 01 00 00 00 00 -> cpuReset=1 the next cycle; write addr 0 / 0; cpuReset=0 again afterwards.
6. With PROGRAM_LOADER_CHECKSUM_EN, A5 01 12 34 56 78 09 -> done=1 (01^12^34^56^78 = 09); repeating with checksum 08 -> error=1, cpuReset=1.

Source files
------------

// File: rtl/program_loader.sv
// Boot-time loader: assembles big-endian 32-bit words from a byte stream into instruction memory.
// Optional macro PROGRAM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte to each frame.
module program_loader #(
  parameter int          ADDRESS_WIDTH  = 8,
  parameter logic [7:0]  START_BYTE     = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 1000000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     byteValid,
  input  logic [7:0]               byteData,
  output logic                     byteReady,
  output logic                     imemWrite,
  output logic [ADDRESS_WIDTH-1:0] imemAddress,
  output logic [31:0]              imemData,
  output logic                     cpuReset,
  output logic                     loading,
  output logic                     done,
  output logic                     error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    CHECK,
`endif
    IDLE,
    COUNT,
    LOAD,
    WRITE,
    DONE
  } state_t;

  state_t        state, stateNext;
  logic [1:0]    byteIndex;
  logic [8:0]    remaining;
  logic [TW-1:0] timeoutCount;
  logic          accept, timerOn, timeoutHit, lastWord;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]    checksum;
`endif

  always_comb begin
    byteReady  = (state != WRITE);
    imemWrite  = (state == WRITE);
    accept     = byteValid && byteReady;
    timerOn    = (state == COUNT) || (state == LOAD);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    timerOn    = timerOn || (state == CHECK);
`endif
    timeoutHit = timerOn && !accept && (timeoutCount == TIMEOUT_LAST);
    lastWord   = (remaining == 9'd1);
    stateNext  = state;
    case (state)
      IDLE, DONE: if (accept && byteData == START_BYTE) stateNext = COUNT;
      COUNT:      if (accept) stateNext = LOAD;
      LOAD:       if (accept && byteIndex == 2'd3) stateNext = WRITE;
      WRITE: begin
        if (!lastWord) stateNext = LOAD;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        else           stateNext = CHECK;
`else
        else           stateNext = DONE;
`endif
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      CHECK:      if (accept) stateNext = (byteData == checksum) ? DONE : IDLE;
`endif
      default:    stateNext = IDLE;
    endcase
    // A byte arriving on the expiry cycle wins over the timeout.
    if (timeoutHit) stateNext = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      imemAddress  <= '0;
      imemData     <= '0;
      cpuReset     <= 1'b1;
      loading      <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      byteIndex    <= '0;
      remaining    <= '0;
      timeoutCount <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      checksum     <= '0;
`endif
    end else begin
      if (!timerOn || accept || timeoutHit) timeoutCount <= '0;
      else                                  timeoutCount <= timeoutCount + TW'(1);
      case (state)
        IDLE, DONE: begin
          if (accept && byteData == START_BYTE) begin
            cpuReset    <= 1'b1;
            loading     <= 1'b1;
            done        <= 1'b0;
            error       <= 1'b0;
            imemAddress <= '0;
            byteIndex   <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            checksum    <= '0;
`endif
          end
        end
        COUNT: begin
          if (accept) begin
            remaining <= (byteData == 8'd0) ? 9'd256 : {1'b0, byteData};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            checksum  <= checksum ^ byteData;
`endif
          end
        end
        LOAD: begin
          if (accept) begin
            imemData  <= {imemData[23:0], byteData};
            byteIndex <= byteIndex + 2'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            checksum  <= checksum ^ byteData;
`endif
          end
        end
        WRITE: begin
          imemAddress <= imemAddress + ADDRESS_WIDTH'(1);
          remaining   <= remaining - 9'd1;
`ifndef PROGRAM_LOADER_CHECKSUM_EN
          if (lastWord) begin
            done     <= 1'b1;
            cpuReset <= 1'b0;
            loading  <= 1'b0;
          end
`endif
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        CHECK: begin
          if (accept) begin
            loading <= 1'b0;
            if (byteData == checksum) begin
              done     <= 1'b1;
              cpuReset <= 1'b0;
            end else begin
              error    <= 1'b1;
            end
          end
        end
`endif
        default: ;
      endcase
      if (timeoutHit) begin
        error   <= 1'b1;
        loading <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: table-driven frames, timeout/reset corner cases and random frames.
module tb_program_loader;
  localparam int TO = 50;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        byteValid = 1'b0;
  logic [7:0]  byteData = 8'h00;
  logic        byteReady, imemWrite, cpuReset, loading, done, error;
  logic [7:0]  imemAddress;
  logic [31:0] imemData;

  program_loader #(.ADDRESS_WIDTH(8), .START_BYTE(8'hA5), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .byteValid(byteValid), .byteData(byteData),
    .byteReady(byteReady), .imemWrite(imemWrite), .imemAddress(imemAddress),
    .imemData(imemData), .cpuReset(cpuReset), .loading(loading), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount = 0;
  int rdyViol = 0;
  int gapMax = 0;
  logic [7:0]  txQ[$];
  logic [7:0]  wrA[$];
  logic [31:0] wrD[$];
  logic [31:0] expQ[$];

  typedef struct {
    int          len;
    logic [7:0]  b [16];
    int          nWr;
    logic [7:0]  lastAddr;
    logic [31:0] lastData;
    logic [7:0]  endAddr;
  } vec_t;
  vec_t vt [4];

  always @(negedge clk) begin
    if (reset) begin
      if (imemWrite) begin
        wrA.push_back(imemAddress);
        wrD.push_back(imemData);
      end
      if (byteReady === imemWrite) rdyViol++;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic sendByte(input logic [7:0] b);
    int g;
    int w;
    g = $urandom_range(gapMax, 0);
    repeat (g) @(negedge clk);
    byteValid = 1'b1;
    byteData  = b;
    w = 0;
    while (!byteReady && w < 8) begin
      @(negedge clk);
      w++;
    end
    if (!byteReady) check("byteReadyWait", 32'(byteReady), 1);
    @(negedge clk);
    byteValid = 1'b0;
    byteData  = 8'($urandom);
  endtask

  task automatic sendAll(input string tag);
    bit seen;
    seen = 0;
    foreach (txQ[i]) begin
      sendByte(txQ[i]);
      if (!seen && txQ[i] == 8'hA5) begin
        seen = 1;
        check({tag, ".startCpuReset"}, 32'(cpuReset), 1);
        check({tag, ".startLoading"}, 32'(loading), 1);
        check({tag, ".startDone"}, 32'(done), 0);
        check({tag, ".startError"}, 32'(error), 0);
      end
    end
  endtask

  task automatic addChecksum();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] x;
    bit on;
    x = 8'h00;
    on = 0;
    foreach (txQ[i]) begin
      if (on) x = x ^ txQ[i];
      else if (txQ[i] == 8'hA5) on = 1;
    end
    txQ.push_back(x);
`endif
  endtask

  task automatic checkWrites(input string tag);
    check({tag, ".nWrites"}, 32'(wrD.size()), 32'(expQ.size()));
    foreach (expQ[i]) begin
      if (i < wrD.size()) begin
        check($sformatf("%s.addr%0d", tag, i), 32'(wrA[i]), 32'(i % 256));
        check($sformatf("%s.data%0d", tag, i), wrD[i], expQ[i]);
      end
    end
  endtask

  task automatic checkDone(input string tag, input logic [7:0] endAddr);
    check({tag, ".done"}, 32'(done), 1);
    check({tag, ".error"}, 32'(error), 0);
    check({tag, ".cpuReset"}, 32'(cpuReset), 0);
    check({tag, ".loading"}, 32'(loading), 0);
    check({tag, ".endAddr"}, 32'(imemAddress), 32'(endAddr));
  endtask

  initial begin
    vt[0] = '{10, '{8'hA5, 8'h02, 8'h3C, 8'h08, 8'h00, 8'h01, 8'h20, 8'h09, 8'h00, 8'h02,
                   8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2, 8'h01, 32'h20090002, 8'h02};
    vt[1] = '{8, '{8'h11, 8'h22, 8'hA5, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1, 8'h00, 32'hDEADBEEF, 8'h01};
    vt[2] = '{6, '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00,
                  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1, 8'h00, 32'h00000000, 8'h01};
    vt[3] = '{15, '{8'h33, 8'hA5, 8'h03, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h01, 8'h02, 8'h03, 8'h04,
                   8'hA5, 8'h00, 8'h00, 8'hA5, 8'h00}, 3, 8'h02, 32'hA50000A5, 8'h03};

    repeat (3) @(negedge clk);
    check("rst.cpuReset", 32'(cpuReset), 1);
    check("rst.imemWrite", 32'(imemWrite), 0);
    check("rst.imemAddress", 32'(imemAddress), 0);
    check("rst.imemData", imemData, 0);
    check("rst.byteReady", 32'(byteReady), 1);
    check("rst.loading", 32'(loading), 0);
    check("rst.done", 32'(done), 0);
    check("rst.error", 32'(error), 0);
    reset = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      wrA.delete(); wrD.delete(); txQ.delete();
      for (int i = 0; i < vt[v].len; i++) txQ.push_back(vt[v].b[i]);
      addChecksum();
      gapMax = (v == 1) ? 5 : 0;
      sendAll(tag);
`ifndef PROGRAM_LOADER_CHECKSUM_EN
      check({tag, ".lastWrStrobe"}, 32'(imemWrite), 1);
      check({tag, ".lastWrAddr"}, 32'(imemAddress), 32'(vt[v].lastAddr));
      check({tag, ".lastWrData"}, imemData, vt[v].lastData);
      check({tag, ".doneDuringWr"}, 32'(done), 0);
      @(negedge clk);
      check({tag, ".doneAfterWr"}, 32'(done), 1);
      check({tag, ".cpuRelAfterWr"}, 32'(cpuReset), 0);
      check({tag, ".strobeAfterWr"}, 32'(imemWrite), 0);
`endif
      repeat (2) @(negedge clk);
      #1;
      check({tag, ".nWrites"}, 32'(wrD.size()), 32'(vt[v].nWr));
      if (wrD.size() > 0) begin
        check({tag, ".lastAddr"}, 32'(wrA[$]), 32'(vt[v].lastAddr));
        check({tag, ".lastData"}, wrD[$], vt[v].lastData);
      end
      checkDone(tag, vt[v].endAddr);
    end

    gapMax = 0;
    wrA.delete(); wrD.delete();
    txQ = '{8'hA5, 8'h01, 8'hDE, 8'hAD};
    sendAll("tmo");
    repeat (TO - 1) @(negedge clk);
    check("tmo.loadingBefore", 32'(loading), 1);
    check("tmo.errorBefore", 32'(error), 0);
    @(negedge clk);
    check("tmo.error", 32'(error), 1);
    check("tmo.loading", 32'(loading), 0);
    check("tmo.cpuReset", 32'(cpuReset), 1);
    check("tmo.done", 32'(done), 0);
    #1;
    check("tmo.noWrite", 32'(wrD.size()), 0);
    txQ = '{8'hA5, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    addChecksum();
    sendAll("tmoRecover");
    repeat (2) @(negedge clk);
    #1;
    expQ = '{32'h11223344};
    checkWrites("tmoRecover");
    checkDone("tmoRecover", 8'h01);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    txQ = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
    sendAll("ckGood");
    check("ckGood.done", 32'(done), 1);
    check("ckGood.cpuReset", 32'(cpuReset), 0);
    check("ckGood.error", 32'(error), 0);
    txQ = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    sendAll("ckBad");
    check("ckBad.error", 32'(error), 1);
    check("ckBad.cpuReset", 32'(cpuReset), 1);
    check("ckBad.done", 32'(done), 0);
    check("ckBad.loading", 32'(loading), 0);
`endif

    for (int f = 0; f < 8; f++) begin
      int n;
      int nw;
      int junk;
      string tag;
      logic [31:0] w;
      logic [7:0]  jb;
      tag = $sformatf("rnd%0d", f);
      n  = (f == 3) ? 0 : $urandom_range(12, 1);
      nw = (n == 0) ? 256 : n;
      txQ.delete(); expQ.delete(); wrA.delete(); wrD.delete();
      junk = $urandom_range(2, 0);
      for (int j = 0; j < junk; j++) begin
        jb = 8'($urandom);
        if (jb == 8'hA5) jb = 8'h5A;
        txQ.push_back(jb);
      end
      txQ.push_back(8'hA5);
      txQ.push_back(8'(n));
      for (int k = 0; k < nw; k++) begin
        w = $urandom;
        expQ.push_back(w);
        txQ.push_back(w[31:24]); txQ.push_back(w[23:16]);
        txQ.push_back(w[15:8]);  txQ.push_back(w[7:0]);
      end
      addChecksum();
      gapMax = (nw == 256) ? 2 : 5;
      sendAll(tag);
      repeat (2) @(negedge clk);
      #1;
      checkWrites(tag);
      checkDone(tag, 8'(nw % 256));
    end

    gapMax = 0;
    txQ = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33};
    sendAll("midRst");
    #2 reset = 1'b0;
    #1;
    check("midRst.loading", 32'(loading), 0);
    check("midRst.cpuReset", 32'(cpuReset), 1);
    check("midRst.imemData", imemData, 0);
    check("midRst.byteReady", 32'(byteReady), 1);
    @(negedge clk);
    reset = 1'b1;
    wrA.delete(); wrD.delete();
    txQ = '{8'hA5, 8'h01, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
    addChecksum();
    sendAll("postRst");
    repeat (2) @(negedge clk);
    #1;
    expQ = '{32'hCAFEF00D};
    checkWrites("postRst");
    checkDone("postRst", 8'h01);

    check("byteReadyOnlyInWrite", 32'(rdyViol), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
